// File: rtl/spatz_cluster_barrier.sv
// spatz_cluster_barrier: hardware barrier with per-core arrive/release handshakes.
// Optional perf outputs (stall events, barrier latency) enabled by SPATZ_BARRIER_PERF_EN.
`default_nettype none

module spatz_cluster_barrier #(
  parameter int unsigned NrCores    = 4,
  parameter int unsigned EpochWidth = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrCores-1:0]             participant_mask_i,
  input  logic [NrCores-1:0]             arrive_valid_i,
  output logic [NrCores-1:0]             arrive_ready_o,
  output logic [NrCores-1:0]             release_valid_o,
  input  logic [NrCores-1:0]             release_ready_i,
  output logic [$clog2(NrCores+1)-1:0]   arrived_count_o,
  output logic [EpochWidth-1:0]          epoch_o,
  output logic [NrCores-1:0]             barrier_stall_o,
  output logic [15:0]                    last_latency_o
);

  localparam int unsigned CntWidth = $clog2(NrCores + 1);

  typedef enum logic [0:0] {
    GATHER  = 1'b0,
    RELEASE = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [NrCores-1:0]    arrived_q, arrived_d;
  logic [NrCores-1:0]    pending_q, pending_d;
  logic [EpochWidth-1:0] epoch_q, epoch_d;
  logic [CntWidth-1:0]   count_q;
  logic [NrCores-1:0]    gather_ready;
  logic [NrCores-1:0]    release_hs;
  logic                  complete;

  function automatic logic [CntWidth-1:0] popcount(input logic [NrCores-1:0] v);
    logic [CntWidth-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NrCores; i++) begin
      cnt = cnt + CntWidth'(v[i]);
    end
    return cnt;
  endfunction

  assign gather_ready   = participant_mask_i & ~arrived_q;
  assign arrive_ready_o = (state_q == GATHER) ? gather_ready : '0;
  assign release_hs     = pending_q & release_ready_i;

  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    pending_d = pending_q;
    epoch_d   = epoch_q;
    complete  = 1'b0;
    case (state_q)
      GATHER: begin
        arrived_d = arrived_q | (arrive_valid_i & gather_ready);
        // An all-zero mask would trivially cover the arrived set; it must hold instead.
        complete  = (arrived_d != '0) && (participant_mask_i != '0) &&
                    ((participant_mask_i & ~arrived_d) == '0);
        if (complete) begin
          state_d   = RELEASE;
          pending_d = arrived_d;
        end
      end
      RELEASE: begin
        pending_d = pending_q & ~release_hs;
        arrived_d = arrived_q & ~release_hs;
        if (pending_d == '0) begin
          state_d = GATHER;
          epoch_d = epoch_q + EpochWidth'(1);
        end
      end
      default: state_d = GATHER;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= GATHER;
      arrived_q <= '0;
      pending_q <= '0;
      epoch_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      pending_q <= pending_d;
      epoch_q   <= epoch_d;
      count_q   <= popcount(arrived_d);
    end
  end

  assign release_valid_o = pending_q;
  assign arrived_count_o = count_q;
  assign epoch_o         = epoch_q;

`ifdef SPATZ_BARRIER_PERF_EN
  logic [NrCores-1:0] stall_q;
  logic [15:0]        lat_cnt_q;
  logic [15:0]        last_lat_q;
  logic [15:0]        lat_inc;

  assign lat_inc = (lat_cnt_q == 16'hFFFF) ? 16'hFFFF : lat_cnt_q + 16'd1;

  // Counter is zero until the first arrival of an epoch, so a barrier of one latches 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q    <= '0;
      lat_cnt_q  <= '0;
      last_lat_q <= '0;
    end else begin
      stall_q <= arrived_d | pending_d;
      if ((state_q == GATHER) && (arrived_d != '0)) begin
        if (complete) begin
          last_lat_q <= lat_inc;
          lat_cnt_q  <= '0;
        end else begin
          lat_cnt_q  <= lat_inc;
        end
      end
    end
  end

  assign barrier_stall_o = stall_q;
  assign last_latency_o  = last_lat_q;
`else
  assign barrier_stall_o = '0;
  assign last_latency_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spatz_cluster_barrier.sv
// Scoreboard bench for spatz_cluster_barrier: set-based reference model, directed plan + random traffic.
`default_nettype none

module tb_spatz_cluster_barrier;

  localparam int N  = 4;
  localparam int EW = 2;

  logic                 clk;
  logic                 rst_ni;
  logic [N-1:0]         mask;
  logic [N-1:0]         valid;
  logic [N-1:0]         rready;
  logic [N-1:0]         arrive_ready;
  logic [N-1:0]         release_valid;
  logic [2:0]           arrived_count;
  logic [EW-1:0]        epoch;
  logic [N-1:0]         stall;
  logic [15:0]          last_latency;

  spatz_cluster_barrier #(.NrCores(N), .EpochWidth(EW)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .participant_mask_i (mask),
    .arrive_valid_i     (valid),
    .arrive_ready_o     (arrive_ready),
    .release_valid_o    (release_valid),
    .release_ready_i    (rready),
    .arrived_count_o    (arrived_count),
    .epoch_o            (epoch),
    .barrier_stall_o    (stall),
    .last_latency_o     (last_latency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned group;
    int unsigned ep;
    int unsigned lat;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  seen   = 0;

  // Reference model state: sets as bitmasks, barrier timing by absolute cycle numbers.
  int unsigned m_arr, m_pend, m_epoch;
  bit          m_releasing;
  int unsigned cyc, first_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned ones(input int unsigned v);
    int unsigned c = 0;
    for (int i = 0; i < N; i++) c += (v >> i) & 1;
    return c;
  endfunction

  task automatic model_clear();
    m_arr = 0; m_pend = 0; m_epoch = 0; m_releasing = 0; first_cyc = 0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    valid  = '0;
    rready = '0;
    rst_ni = 1'b0;
    #1;
    chk("rst_count", arrived_count, 0);
    chk("rst_release", release_valid, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_ready", arrive_ready, mask);
    chk("rst_stall", stall, 0);
    chk("rst_latency", last_latency, 0);
    model_clear();
    q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic cycle(input logic [N-1:0] m, input logic [N-1:0] v, input logic [N-1:0] rr);
    int unsigned exp_ready, hs, nd, full;
    @(negedge clk);
    mask = m; valid = v; rready = rr;
    #1;
    full = (1 << N) - 1;
    exp_ready = m_releasing ? 0 : (int'(m) & ~m_arr & full);
    chk("arrive_ready", arrive_ready, exp_ready);
    chk("arrived_count", arrived_count, ones(m_arr));
    chk("epoch", epoch, m_epoch);
    chk("release_valid", release_valid, m_pend);
`ifdef SPATZ_BARRIER_PERF_EN
    chk("stall", stall, m_arr | m_pend);
`else
    chk("stall", stall, 0);
`endif
    if (!m_releasing) begin
      hs = int'(v) & exp_ready;
      nd = m_arr | hs;
      if (m_arr == 0 && hs != 0) first_cyc = cyc;
      if (nd != 0 && m != 0 && (int'(m) & ~nd) == 0) begin
        q.push_back('{group: nd, ep: m_epoch,
                      lat: ((cyc - first_cyc + 1) > 65535) ? 65535 : (cyc - first_cyc + 1)});
        m_pend = nd;
        m_releasing = 1;
      end
      m_arr = nd;
    end else begin
      hs = m_pend & int'(rr);
      m_pend &= ~hs;
      m_arr  &= ~hs;
      if (m_pend == 0) begin
        m_releasing = 0;
        m_epoch = (m_epoch + 1) % (1 << EW);
      end
    end
    cyc++;
  endtask

  // Monitor: each fresh release presented by the DUT is matched against the next expected barrier.
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    #2;
    if (rst_ni && release_valid != '0 && !prev_rv) begin
      if (q.size() == 0) begin
        chk("unexpected_release", release_valid, 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        seen++;
        chk("sb_group", release_valid, e.group);
        chk("sb_epoch", epoch, e.ep);
        chk("sb_count", arrived_count, ones(e.group));
`ifdef SPATZ_BARRIER_PERF_EN
        chk("sb_latency", last_latency, e.lat);
`else
        chk("sb_latency", last_latency, 0);
`endif
      end
    end
    prev_rv = (release_valid != '0);
  end

  initial begin
    logic [N-1:0] v, m;
    rst_ni = 1'b0; mask = 4'hF; valid = '0; rready = '0;
    cyc = 0;
    model_clear();
    reset_pulse();

    // Staggered arrivals at 0, 3, 5, 9 then full release.
    for (int t = 0; t < 10; t++) begin
      v = '0;
      if (t == 0) v = 4'b0001;
      if (t == 3) v = 4'b0010;
      if (t == 5) v = 4'b0100;
      if (t == 9) v = 4'b1000;
      cycle(4'hF, v, 4'h0);
    end
    cycle(4'hF, 4'h0, 4'hF);
    cycle(4'hF, 4'h0, 4'h0);

    // Non-participant requesting, simultaneous arrivals of 0 and 2.
    cycle(4'b0101, 4'b0010, 4'h0);
    cycle(4'b0101, 4'b0010, 4'h0);
    cycle(4'b0101, 4'b0111, 4'h0);
    cycle(4'b0101, 4'b0010, 4'h0);
    cycle(4'b0101, 4'b0000, 4'hF);
    cycle(4'b0101, 4'b0000, 4'h0);

    // Release backpressure on core 2.
    cycle(4'hF, 4'hF, 4'h0);
    for (int t = 0; t < 7; t++) cycle(4'hF, 4'h0, 4'b1011);
    cycle(4'hF, 4'h0, 4'hF);
    cycle(4'hF, 4'h0, 4'h0);

    // Core 3 arrives, then drops out of the mask.
    cycle(4'hF, 4'b1000, 4'h0);
    cycle(4'b0111, 4'h0, 4'h0);
    cycle(4'b0111, 4'b0111, 4'h0);
    cycle(4'b0111, 4'h0, 4'hF);
    cycle(4'b0111, 4'h0, 4'h0);

    // Barrier of one.
    cycle(4'b0010, 4'b0010, 4'h0);
    cycle(4'b0010, 4'h0, 4'hF);
    cycle(4'b0010, 4'h0, 4'h0);

    // Two-core spread of ten cycles (arrivals at 0 and 9).
    for (int t = 0; t < 10; t++) cycle(4'b0011, (t == 0) ? 4'b0001 : ((t == 9) ? 4'b0010 : 4'b0000), 4'h0);
    cycle(4'b0011, 4'h0, 4'hF);
    cycle(4'b0011, 4'h0, 4'h0);

    // All-zero mask holds arrived cores until mask covers only them.
    cycle(4'hF, 4'b0011, 4'h0);
    for (int t = 0; t < 3; t++) cycle(4'h0, 4'hF, 4'h0);
    cycle(4'b0011, 4'h0, 4'h0);
    cycle(4'b0011, 4'h0, 4'hF);
    cycle(4'b0011, 4'h0, 4'h0);

    // Reset in the middle of a barrier.
    cycle(4'hF, 4'b0011, 4'h0);
    cycle(4'hF, 4'h0, 4'h0);
    reset_pulse();

    // Randomized traffic with occasional mask changes and resets.
    for (int t = 0; t < 600; t++) begin
      m = ($urandom_range(0, 4) == 0) ? N'($urandom) : 4'hF;
      v = N'($urandom);
      if ($urandom_range(0, 250) == 0) reset_pulse();
      else cycle(m, v, N'($urandom));
    end

    for (int t = 0; t < 6; t++) cycle(4'hF, 4'h0, 4'hF);
    @(negedge clk); #3;
    chk("scoreboard_drained", q.size(), 0);
    chk("events_seen", (seen > 5) ? 1 : 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
